// File: rtl/axis_gen_pkg.sv
// -----------------------------------------------------------------------------
// axis_gen_pkg
// Shared definitions for the axis_data_generator_cntr run-time sequencer:
//   - seq_state_t   : sequencer FSM state encoding
//   - wd_cnt_width(): watchdog stall-counter width for a given timeout
// -----------------------------------------------------------------------------
package axis_gen_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_GAP       = 3'd2,
    S_STOP_WAIT = 3'd3,
    S_ERR       = 3'd4
  } seq_state_t;

  // Counter must hold 0..ticks; a disabled watchdog (ticks=0) still gets a
  // one-bit counter so the vector is never zero-width.
  function automatic int unsigned wd_cnt_width(input int unsigned ticks);
    return (ticks == 0) ? 1 : $clog2(ticks + 1);
  endfunction

endpackage

// File: rtl/axis_gen_watchdog.sv
// -----------------------------------------------------------------------------
// axis_gen_watchdog
// Counts consecutive stall cycles and flags expiry on the TIMEOUT_TICKS-th one.
// TIMEOUT_TICKS = 0 disables expiry.
// Ports:
//   clk_i      in  clock (rising edge)
//   a_rst_n_i  in  asynchronous active-low reset
//   en_i       in  count this cycle as a stall
//   clr_i      in  clear the stall count (dominates en_i)
//   expire_o   out high in the cycle that completes TIMEOUT_TICKS stalls
// -----------------------------------------------------------------------------
module axis_gen_watchdog
  import axis_gen_pkg::*;
#(
  parameter int unsigned TIMEOUT_TICKS = 1024
) (
  input  logic clk_i,
  input  logic a_rst_n_i,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam int unsigned     CNT_W = wd_cnt_width(TIMEOUT_TICKS);
  localparam logic [CNT_W-1:0] LIMIT =
    (TIMEOUT_TICKS == 0) ? '0 : CNT_W'(TIMEOUT_TICKS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_hit;

  // Expiry is flagged combinationally on the stall that would bring the
  // count to TIMEOUT_TICKS, so the FSM reacts after exactly that many stalls.
  assign w_hit    = (TIMEOUT_TICKS != 0) && en_i && !clr_i && (r_cnt == LIMIT);
  assign expire_o = w_hit;

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i && !w_hit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/axis_gen_sequencer.sv
// -----------------------------------------------------------------------------
// axis_gen_sequencer
// Run-time controller for axis_data_generator_cntr. Drives the generator
// enable, watches its AXI-Stream handshake and sequences a programmed number
// of packets (or runs continuously) with an idle gap between packets.
// Ports:
//   clk_i, a_rst_n_i          clock / async active-low reset
//   start_i, stop_i           single-cycle control requests
//   continuous_i, pack_num_i,
//   gap_i                     configuration, latched on an accepted start
//   axis_tvalid_i/tready_i/
//   axis_tlast_i              monitored stream handshake
//   gen_enable_o              registered generator enable
//   busy_o                    high in RUN, GAP and STOP_WAIT
//   done_o                    one-cycle pulse at normal or stopped completion
//   error_o                   high while in ERR (watchdog expiry)
//   pack_cnt_o, beat_cnt_o    packets completed / beats in current packet
// -----------------------------------------------------------------------------
module axis_gen_sequencer
  import axis_gen_pkg::*;
#(
  parameter int unsigned PACK_CNT_WIDTH = 32,
  parameter int unsigned GAP_WIDTH      = 16,
  parameter int unsigned BEAT_CNT_WIDTH = 16,
  parameter int unsigned TIMEOUT_TICKS  = 1024
) (
  input  logic                      clk_i,
  input  logic                      a_rst_n_i,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic                      continuous_i,
  input  logic [PACK_CNT_WIDTH-1:0] pack_num_i,
  input  logic [GAP_WIDTH-1:0]      gap_i,
  input  logic                      axis_tvalid_i,
  input  logic                      axis_tready_i,
  input  logic                      axis_tlast_i,
  output logic                      gen_enable_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o,
  output logic [PACK_CNT_WIDTH-1:0] pack_cnt_o,
  output logic [BEAT_CNT_WIDTH-1:0] beat_cnt_o
);

  seq_state_t r_state, w_state_nxt;

  logic                      r_cont;
  logic [PACK_CNT_WIDTH-1:0] r_pack_num;
  logic [GAP_WIDTH-1:0]      r_gap;
  logic [GAP_WIDTH-1:0]      r_gap_cnt;
  logic [PACK_CNT_WIDTH-1:0] r_pack_cnt;
  logic [BEAT_CNT_WIDTH-1:0] r_beat_cnt;
  logic                      r_gen_enable;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_error;

  logic                      w_hs;
  logic                      w_last_hs;
  logic [PACK_CNT_WIDTH-1:0] w_pack_inc;
  logic                      w_finite_end;
  logic                      w_streaming;
  logic                      w_counting;
  logic                      w_wd_expire;
  logic                      w_start_load;
  logic                      w_gap_load;
  logic                      w_done_nxt;

  assign w_hs         = axis_tvalid_i & axis_tready_i;
  assign w_last_hs    = w_hs & axis_tlast_i;
  assign w_pack_inc   = r_pack_cnt + 1'b1;
  assign w_finite_end = !r_cont && (w_pack_inc == r_pack_num);
  assign w_streaming  = (r_state == S_RUN) || (r_state == S_STOP_WAIT);
  assign w_counting   = w_streaming || (r_state == S_GAP);

  axis_gen_watchdog #(
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) u_watchdog (
    .clk_i     (clk_i),
    .a_rst_n_i (a_rst_n_i),
    .en_i      (w_streaming && !axis_tvalid_i),
    .clr_i     (!w_streaming || axis_tvalid_i),
    .expire_o  (w_wd_expire)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_done_nxt   = 1'b0;
    w_start_load = 1'b0;
    w_gap_load   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start_i && !stop_i) begin
          w_start_load = 1'b1;
          if (!continuous_i && (pack_num_i == '0)) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (w_wd_expire) begin
          w_state_nxt = S_ERR;
        end else if (w_last_hs) begin
          // A stop arriving with the final beat is treated as already pending.
          if (w_finite_end || stop_i) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else if (r_gap != '0) begin
            w_state_nxt = S_GAP;
            w_gap_load  = 1'b1;
          end
        end else if (stop_i) begin
          w_state_nxt = S_STOP_WAIT;
        end
      end
      S_STOP_WAIT: begin
        if (w_wd_expire) begin
          w_state_nxt = S_ERR;
        end else if (w_last_hs) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      S_GAP: begin
        if (stop_i) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else if (r_gap_cnt == '0) begin
          w_state_nxt = S_RUN;
        end
      end
      S_ERR: begin
        if (stop_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, outputs (decoded from next state so they are registered and aligned
  // with the state they describe), configuration and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      r_state      <= S_IDLE;
      r_gen_enable <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_gen_enable <= (w_state_nxt == S_RUN) || (w_state_nxt == S_STOP_WAIT);
      r_busy       <= (w_state_nxt == S_RUN) || (w_state_nxt == S_STOP_WAIT) ||
                      (w_state_nxt == S_GAP);
      r_done       <= w_done_nxt;
      r_error      <= (w_state_nxt == S_ERR);
    end
  end

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      r_cont     <= 1'b0;
      r_pack_num <= '0;
      r_gap      <= '0;
      r_pack_cnt <= '0;
      r_beat_cnt <= '0;
    end else if (w_start_load) begin
      r_cont     <= continuous_i;
      r_pack_num <= pack_num_i;
      r_gap      <= gap_i;
      r_pack_cnt <= '0;
      r_beat_cnt <= '0;
    end else if (w_counting) begin
      // Beats drained by the generator during GAP are counted but never close
      // a packet; only RUN/STOP_WAIT advance the packet count.
      if (w_last_hs && w_streaming) begin
        r_pack_cnt <= w_pack_inc;
        r_beat_cnt <= '0;
      end else if (w_hs) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

  // Loaded with gap-1 so the GAP state lasts exactly gap cycles.
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      r_gap_cnt <= '0;
    end else if (w_gap_load) begin
      r_gap_cnt <= r_gap - 1'b1;
    end else if ((r_state == S_GAP) && (r_gap_cnt != '0)) begin
      r_gap_cnt <= r_gap_cnt - 1'b1;
    end
  end

  assign gen_enable_o = r_gen_enable;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign error_o      = r_error;
  assign pack_cnt_o   = r_pack_cnt;
  assign beat_cnt_o   = r_beat_cnt;

endmodule

// File: doc/axis_gen_sequencer.md
Name: axis_gen_sequencer

Overview:
- Run-time controller for axis_data_generator_cntr.
- Drives the generator's enable_i and monitors the generator's AXI-Stream output (tvalid/tready/tlast).
- Sequences a programmed number of packets, or runs continuously, with a programmable idle gap between packets.
- Provides graceful stop at a packet boundary, a source-stall watchdog and status counters for software/test control.

Parameters:
- PACK_CNT_WIDTH, 32: width of the packet-count configuration and packet counter.
- GAP_WIDTH, 16: width of the inter-packet gap setting, in clock cycles.
- BEAT_CNT_WIDTH, 16: width of the per-packet beat counter.
- TIMEOUT_TICKS, 1024: watchdog limit in stall cycles; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- a_rst_n_i  in  1  asynchronous active-low reset (one clock, async assert).
- start_i  in  1  single-cycle start request; honoured only in IDLE.
- stop_i  in  1  single-cycle stop request; also clears ERR.
- continuous_i  in  1  1 = ignore pack_num_i and run until stopped; latched on start.
- pack_num_i  in  PACK_CNT_WIDTH  number of packets to send; latched on start.
- gap_i  in  GAP_WIDTH  idle cycles between packets; latched on start.
- axis_tvalid_i  in  1  monitored generator tvalid.
- axis_tready_i  in  1  monitored sink tready.
- axis_tlast_i  in  1  monitored generator tlast.
- gen_enable_o  out  1  registered enable to the generator.
- busy_o  out  1  high in RUN, GAP and STOP_WAIT.
- done_o  out  1  one-cycle pulse when a sequence ends normally or by stop.
- error_o  out  1  high while in ERR (watchdog expiry).
- pack_cnt_o  out  PACK_CNT_WIDTH  packets completed in the current or last sequence.
- beat_cnt_o  out  BEAT_CNT_WIDTH  handshaked beats in the current packet.

Behaviour:
- Reset (async, a_rst_n_i=0):
  - state=IDLE.
  - gen_enable_o, busy_o, done_o, error_o = 0.
  - pack_cnt_o = 0, beat_cnt_o = 0.
  - Latched configuration = 0.
- Definitions:
  - hs = tvalid & tready.
  - last_hs = hs & tlast.
  - All outputs are registered.
- IDLE:
  - start_i=1 & stop_i=0: latch configuration; clear pack_cnt_o and beat_cnt_o.
    - If continuous=0 & pack_num=0: pulse done_o next cycle and stay IDLE; gen_enable_o never asserts.
    - Otherwise go to RUN; gen_enable_o=1 from the next cycle.
  - start_i and stop_i asserted together: stop wins, start is ignored.
- RUN (gen_enable_o=1):
  - Each hs increments beat_cnt_o; it wraps at 2^BEAT_CNT_WIDTH.
  - On last_hs: pack_cnt_o increments and beat_cnt_o clears. Next state, in priority order:
    - continuous=0 & pack_cnt_o+1 == pack_num: IDLE, done_o pulse.
    - Otherwise, stop pending: IDLE, done_o pulse.
    - Otherwise, gap=0: stay in RUN with enable held high, giving back-to-back packets.
    - Otherwise: GAP; gen_enable_o=0 in the cycle after last_hs.
  - stop_i without last_hs in the same cycle: go to STOP_WAIT.
  - stop_i coincident with last_hs: treated as stop pending, so go to IDLE with done_o pulse.
- STOP_WAIT:
  - Same as RUN (enable high, counting continues); finishes the current packet.
  - On last_hs: go to IDLE, pulse done_o.
- GAP (gen_enable_o=0):
  - Counts down exactly gap cycles, then returns to RUN; enable is high again on the following cycle.
  - stop_i in GAP: go to IDLE immediately, pulse done_o.
  - Any hs in GAP is still counted; the generator may drain its registered beat.
- Watchdog:
  - In RUN or STOP_WAIT, counts consecutive cycles with tvalid=0.
  - Clears on any tvalid=1 cycle.
  - tready=0 (backpressure) does not count.
  - Reaching TIMEOUT_TICKS: go to ERR, gen_enable_o=0, error_o=1.
- ERR:
  - Holds until stop_i, then goes to IDLE with error_o=0.
  - No done_o pulse on leaving ERR.
  - start_i is ignored in ERR.
- Counters and inputs:
  - Continuous mode: pack_cnt_o wraps modulo 2^PACK_CNT_WIDTH.
  - start_i while busy is ignored.
  - Configuration inputs may change freely while busy.
- Reset mid-operation: immediate return to reset values; gen_enable_o drops asynchronously.

Decomposition:
- Shared package axis_gen_pkg holds the state encoding and the watchdog counter width.
  - States: IDLE, RUN, GAP, STOP_WAIT, ERR.
  - Watchdog width = clog2(TIMEOUT_TICKS+1).
- One sub-module, axis_gen_watchdog: stall counter with enable/clear inputs and an expire output.
- FSM, gap counter and status counters stay in the top level.

Test Plan:
- Finite run: pack_num=4, gap=0, generator with PACK_SIZE=1024, tready=1 → 4096 hs; enable never drops between packets; pack_cnt_o=4; single done_o pulse; return to IDLE.
- Gap and backpressure: pack_num=3, gap=10, random tready → exactly 10 cycles of enable=0 after each of the first 2 last_hs; beat_cnt_o reaches 1023 before each last_hs.
- Graceful stop: continuous=1, stop_i at beat 500 of packet 2 → STOP_WAIT; enable stays high until packet 2's last_hs; pack_cnt_o=2; done_o pulses once.
- Boundary cases:
  - pack_num=0, continuous=0 → done_o one cycle later, enable never asserts.
  - start_i with stop_i in the same cycle → nothing happens.
- Watchdog: TIMEOUT_TICKS=16, force tvalid=0 for 16 cycles in RUN → error_o=1, enable=0.
  - tready=0 for 100 cycles with tvalid=1 → no error.
  - stop_i in ERR → IDLE, error_o=0.
- Async reset at beat 300 mid-GAP and mid-RUN → all outputs 0 immediately; a new start_i runs a clean sequence.
